// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one request at a time to a combinational ALU, waits SETTLE_CYCLES, then returns the captured result
//   clk, reset                      clock and async active-high reset
//   req_valid/req_ready, req_*      operation request channel
//   alu_a/alu_b/alu_function        registered ALU operands, held until the next accepted request
//   alu_result, alu_is_*            ALU outputs, captured on the last settle edge
//   rsp_valid/rsp_ready, rsp_*      response channel; rsp_err flags an illegal function code
//   sticky_ovf, sticky_clr          sticky overflow flag and its synchronous clear
//   op_count                        saturating count of completed response handshakes
module alu_issue_ctrl #(
  parameter int DATA_W        = 8,
  parameter int FUNC_W        = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [FUNC_W-1:0] req_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_function,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_is_zero,
  input  logic              alu_is_sign,
  input  logic              alu_is_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic              sticky_ovf,
  input  logic              sticky_clr,
  output logic [CNT_W-1:0]  op_count
);
  localparam int SC_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state, state_n;
  logic [SC_W-1:0] settle_cnt;
  logic accept, capture, done;
  assign req_ready = (state == IDLE) && !reset;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:    begin accept = req_valid; state_n = req_valid ? SETTLE : IDLE; end
      SETTLE:  begin capture = settle_cnt == '0; state_n = capture ? RESP : SETTLE; end
      RESP:    begin done = rsp_ready; state_n = rsp_ready ? IDLE : RESP; end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_function <= '0;
      settle_cnt   <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_sign     <= 1'b0;
      rsp_ovf      <= 1'b0;
      rsp_err      <= 1'b0;
      sticky_ovf   <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        alu_a        <= req_a;
        alu_b        <= req_b;
        alu_function <= req_func;
        settle_cnt   <= SC_W'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE) settle_cnt <= settle_cnt - SC_W'(1);
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_zero   <= alu_is_zero;
        rsp_sign   <= alu_is_sign;
        rsp_ovf    <= alu_is_ovf;
        rsp_err    <= alu_function > FUNC_W'(4);
      end
      if (done) begin
        rsp_valid <= 1'b0;
        op_count  <= &op_count ? op_count : op_count + CNT_W'(1);
      end
      sticky_ovf <= (capture && alu_is_ovf) || (sticky_ovf && !sticky_clr);
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl against a behavioural model (SETTLE 1/CNT 16 and SETTLE 3/CNT 2)
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset[2], req_valid[2], req_ready[2], rsp_valid[2], rsp_ready[2];
  logic [7:0] req_a[2], req_b[2], alu_a[2], alu_b[2], rsp_result[2];
  logic [2:0] req_func[2], alu_function[2];
  logic       rsp_zero[2], rsp_sign[2], rsp_ovf[2], rsp_err[2], sticky_ovf[2], sticky_clr[2];
  logic [15:0] op_count[2];
  int npass = 0, nchk = 0;
  int cnt_m[2];
  bit st_m[2];
  function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    int s;
    logic [7:0] r;
    logic v;
    s = 0;
    if (f == 0) s = int'($signed(a)) + int'($signed(b));
    else if (f == 1) s = int'($signed(a)) - int'($signed(b));
    r = f <= 1 ? s[7:0] : f == 2 ? a & b : f == 3 ? a | b : f == 4 ? a ^ b : 8'h00;
    v = (f <= 1) && (s > 127 || s < -128);
    return {v, r[7], r == 8'h00, r};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int SC = g == 0 ? 1 : 3;
    localparam int CW = g == 0 ? 16 : 2;
    logic [CW-1:0] oc;
    logic [10:0] alu_o;
    assign alu_o = alu_ref(alu_a[g], alu_b[g], alu_function[g]);
    assign op_count[g] = 16'(oc);
    alu_issue_ctrl #(.SETTLE_CYCLES(SC), .CNT_W(CW)) u_dut (
      .clk(clk), .reset(reset[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_a(req_a[g]), .req_b(req_b[g]), .req_func(req_func[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_function(alu_function[g]),
      .alu_result(alu_o[7:0]), .alu_is_zero(alu_o[8]), .alu_is_sign(alu_o[9]), .alu_is_ovf(alu_o[10]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_result(rsp_result[g]),
      .rsp_zero(rsp_zero[g]), .rsp_sign(rsp_sign[g]), .rsp_ovf(rsp_ovf[g]), .rsp_err(rsp_err[g]),
      .sticky_ovf(sticky_ovf[g]), .sticky_clr(sticky_clr[g]), .op_count(oc)
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask
  task automatic check_reset(input int i);
    check("rst_req_ready", req_ready[i], 0);
    check("rst_rsp_valid", rsp_valid[i], 0);
    check("rst_alu", {alu_a[i], alu_b[i], alu_function[i]}, 0);
    check("rst_rsp", {rsp_result[i], rsp_zero[i], rsp_sign[i], rsp_ovf[i], rsp_err[i]}, 0);
    check("rst_sticky", sticky_ovf[i], 0);
    check("rst_count", op_count[i], 0);
  endtask
  task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f, input int hold, input bit clr);
    logic [10:0] e;
    int n;
    e = alu_ref(a, b, f);
    n = i == 0 ? 1 : 3;
    req_a[i] = a; req_b[i] = b; req_func[i] = f; req_valid[i] = 1'b1;
    check("req_ready_idle", req_ready[i], 1);
    @(posedge clk); #1;
    req_a[i] = 8'($urandom); req_b[i] = 8'($urandom); req_func[i] = 3'($urandom);
    check("alu_issue", {alu_a[i], alu_b[i], alu_function[i]}, {a, b, f});
    for (int k = 0; k < n; k++) begin
      check("settle_rsp_valid", rsp_valid[i], 0);
      check("settle_req_ready", req_ready[i], 0);
      rsp_ready[i] = 1'($urandom);
      sticky_clr[i] = k == n - 1 ? clr : 1'b0;
      @(posedge clk); #1;
    end
    st_m[i] = e[10] ? 1'b1 : sticky_clr[i] ? 1'b0 : st_m[i];
    rsp_ready[i] = 1'b0; sticky_clr[i] = 1'b0;
    check("rsp_valid", rsp_valid[i], 1);
    check("rsp_data", {rsp_ovf[i], rsp_sign[i], rsp_zero[i], rsp_result[i]}, e);
    check("rsp_err", rsp_err[i], f > 4);
    check("sticky", sticky_ovf[i], st_m[i]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_rsp", {rsp_valid[i], rsp_ovf[i], rsp_sign[i], rsp_zero[i], rsp_result[i]}, {1'b1, e});
      check("hold_req_ready", req_ready[i], 0);
      check("hold_alu", {alu_a[i], alu_b[i], alu_function[i]}, {a, b, f});
    end
    req_valid[i] = 1'b0; rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    cnt_m[i] = cnt_m[i] == (i == 0 ? 65535 : 3) ? cnt_m[i] : cnt_m[i] + 1;
    check("done_rsp_valid", rsp_valid[i], 0);
    check("done_req_ready", req_ready[i], 1);
    check("op_count", op_count[i], cnt_m[i]);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; rsp_ready[i] = 1'b0; sticky_clr[i] = 1'b0;
      req_a[i] = '0; req_b[i] = '0; req_func[i] = '0; cnt_m[i] = 0; st_m[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_reset(i);
    reset[0] = 1'b0; reset[1] = 1'b0;
    #1;
    do_op(0, 8'd100, 8'd50, 3'd0, 0, 1'b1);
    check("add_result", rsp_result[0], 8'h96);
    sticky_clr[0] = 1'b1;
    @(posedge clk); #1;
    sticky_clr[0] = 1'b0; st_m[0] = 1'b0;
    check("sticky_clear", sticky_ovf[0], 0);
    do_op(0, 8'd5, 8'd5, 3'd1, 1, 1'b0);
    do_op(0, 8'h80, 8'd1, 3'd1, 0, 1'b0);
    check("sub_wrap", rsp_result[0], 8'h7f);
    do_op(0, 8'd3, 8'd4, 3'd7, 10, 1'b0);
    for (int t = 0; t < 60; t++)
      do_op(0, 8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    do_op(1, 8'd100, 8'd50, 3'd0, 0, 1'b0);
    req_a[1] = 8'd9; req_b[1] = 8'd9; req_func[1] = 3'd0; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset[1] = 1'b1;
    #1;
    cnt_m[1] = 0; st_m[1] = 1'b0;
    check_reset(1);
    repeat (3) @(posedge clk);
    #1;
    reset[1] = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid[1], 0);
    check("abort_req_ready", req_ready[1], 1);
    for (int t = 0; t < 5; t++)
      do_op(1, 8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    check("sat_count", op_count[1], 3);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
